// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM state type, bus widths and default timeout for the Wishbone host master
package wb_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
  localparam int WB_ADR_W = 10;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam int TIMEOUT_CYC_DEF = 256;
endpackage

// File: rtl/wb_host_master_if.sv
// wb_host_master_if: host request/response handshake plus Wishbone master bus
// master: the bridge (takes host requests and slave responses, drives Wishbone and host responses)
// slave: the environment (host side and Wishbone slave)
interface wb_host_master_if;
  import wb_pkg::*;
  logic req_valid, req_ready, req_we;
  logic [WB_ADR_W-1:0] req_adr;
  logic [WB_DAT_W-1:0] req_wdat;
  logic [WB_SEL_W-1:0] req_sel;
  logic rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [WB_DAT_W-1:0] rsp_rdat;
  logic [11:2] wb_adr_i;
  logic [WB_DAT_W-1:0] wb_dat_i, wb_dat_o;
  logic [WB_SEL_W-1:0] wb_sel_i;
  logic wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
  modport master (
    input  req_valid, req_we, req_adr, req_wdat, req_sel, rsp_ready, wb_dat_o, wb_ack_o, wb_err_o,
    output req_ready, rsp_valid, rsp_rdat, rsp_err, rsp_timeout,
           wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i
  );
  modport slave (
    output req_valid, req_we, req_adr, req_wdat, req_sel, rsp_ready, wb_dat_o, wb_ack_o, wb_err_o,
    input  req_ready, rsp_valid, rsp_rdat, rsp_err, rsp_timeout,
           wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i
  );
endinterface

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: bus-cycle wait counter; clr_i zeroes, en_i counts, expired_o at TIMEOUT_CYC-1
module wb_timeout_cnt
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : en_i ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) begin
    cnt_q <= rst ? '0 : cnt_d;
  end
  assign expired_o = cnt_q == 16'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/wb_host_master.sv
// wb_host_master: single-outstanding host-to-Wishbone bridge with err and timeout reporting
// ports: wb_clk_i, wb_rst_i (sync, active high), h (wb_host_master_if.master: host req/rsp + Wishbone)
module wb_host_master
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic             wb_clk_i,
  input logic             wb_rst_i,
  wb_host_master_if.master h
);
  state_e state_q, state_d;
  logic we_q, err_q, to_q, expired, bus, resp, accept, done;
  logic [WB_ADR_W-1:0] adr_q;
  logic [WB_DAT_W-1:0] wdat_q, rdat_q, rdat_d;
  logic [WB_SEL_W-1:0] sel_q;
  assign bus = state_q == BUS;
  assign resp = state_q == RESP;
  assign accept = state_q == IDLE && h.req_valid;
  // ack/err take priority over a timeout expiring in the same cycle
  assign done = bus && (h.wb_ack_o || h.wb_err_o || expired);
  // read data survives only a clean read ack; err wins over ack
  assign rdat_d = (h.wb_err_o || !h.wb_ack_o || we_q) ? '0 : h.wb_dat_o;
  wb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_cnt (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .clr_i(!bus),
    .en_i(bus),
    .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = h.req_valid ? BUS : IDLE;
      BUS:     state_d = done ? RESP : BUS;
      RESP:    state_d = h.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q   <= h.req_we;
        adr_q  <= h.req_adr;
        wdat_q <= h.req_wdat;
        sel_q  <= h.req_sel;
      end
      if (done) begin
        rdat_q <= rdat_d;
        err_q  <= h.wb_err_o;
        to_q   <= !h.wb_err_o && !h.wb_ack_o;
      end
    end
  end
  assign h.req_ready   = state_q == IDLE;
  assign h.wb_cyc_i    = bus;
  assign h.wb_stb_i    = bus;
  assign h.wb_we_i     = bus && we_q;
  assign h.wb_adr_i    = bus ? adr_q : '0;
  assign h.wb_dat_i    = bus ? wdat_q : '0;
  assign h.wb_sel_i    = bus ? sel_q : '0;
  assign h.rsp_valid   = resp;
  assign h.rsp_rdat    = resp ? rdat_q : '0;
  assign h.rsp_err     = resp && err_q;
  assign h.rsp_timeout = resp && to_q;
endmodule

// File: tb/tb_wb_host_master.sv
// tb_wb_host_master: directed self-checking bench for wb_host_master (TIMEOUT_CYC=8)
module tb_wb_host_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  wb_host_master_if bus ();
  wb_host_master #(.TIMEOUT_CYC(8)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .h(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_req(input logic we, input logic [9:0] adr, input logic [31:0] wdat, input logic [3:0] sel);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_adr   = adr;
    bus.req_wdat  = wdat;
    bus.req_sel   = sel;
    tick();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_adr   = '0;
    bus.req_wdat  = '0;
    bus.req_sel   = '0;
  endtask
  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask
  task automatic check_bus(input string tag, input logic we, input logic [9:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    chk({tag, "_cyc"}, 32'(bus.wb_cyc_i), 32'd1);
    chk({tag, "_stb"}, 32'(bus.wb_stb_i), 32'd1);
    chk({tag, "_we"}, 32'(bus.wb_we_i), 32'(we));
    chk({tag, "_adr"}, 32'(bus.wb_adr_i), 32'(adr));
    chk({tag, "_dat"}, bus.wb_dat_i, dat);
    chk({tag, "_sel"}, 32'(bus.wb_sel_i), 32'(sel));
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd0);
  endtask
  task automatic check_rsp(input string tag, input logic [31:0] rdat, input logic err, input logic to);
    chk({tag, "_cyc"}, 32'(bus.wb_cyc_i), 32'd0);
    chk({tag, "_adr0"}, 32'(bus.wb_adr_i), 32'd0);
    chk({tag, "_vld"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_rdat"}, bus.rsp_rdat, rdat);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'(err));
    chk({tag, "_to"}, 32'(bus.rsp_timeout), 32'(to));
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd0);
  endtask
  task automatic check_idle(input string tag);
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_vld"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_cyc"}, 32'(bus.wb_cyc_i), 32'd0);
    chk({tag, "_stb"}, 32'(bus.wb_stb_i), 32'd0);
    chk({tag, "_dat"}, bus.wb_dat_i, 32'd0);
    chk({tag, "_sel"}, 32'(bus.wb_sel_i), 32'd0);
    chk({tag, "_rdat"}, bus.rsp_rdat, 32'd0);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_adr   = '0;
    bus.req_wdat  = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b0;
    bus.wb_dat_o  = '0;
    bus.wb_ack_o  = 1'b0;
    bus.wb_err_o  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_idle("reset");
    // write, ack on the third bus cycle
    do_req(1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    check_bus("wr_c1", 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    tick();
    check_bus("wr_c2", 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    tick();
    check_bus("wr_c3", 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    bus.wb_ack_o = 1'b1;
    bus.wb_dat_o = 32'h0BADF00D;
    tick();
    bus.wb_ack_o = 1'b0;
    bus.wb_dat_o = '0;
    check_rsp("wr_rsp", 32'd0, 1'b0, 1'b0);
    tick();
    check_rsp("wr_hold", 32'd0, 1'b0, 1'b0);
    finish_rsp();
    check_idle("wr_done");
    // zero-wait read at top address
    do_req(1'b0, 10'h3FF, 32'd0, 4'hF);
    check_bus("rd_c1", 1'b0, 10'h3FF, 32'd0, 4'hF);
    bus.wb_ack_o = 1'b1;
    bus.wb_dat_o = 32'h12345678;
    tick();
    bus.wb_ack_o = 1'b0;
    bus.wb_dat_o = '0;
    check_rsp("rd_rsp", 32'h12345678, 1'b0, 1'b0);
    finish_rsp();
    check_idle("rd_done");
    // ack and err together: err wins
    do_req(1'b0, 10'h055, 32'd0, 4'h3);
    check_bus("ae_c1", 1'b0, 10'h055, 32'd0, 4'h3);
    bus.wb_ack_o = 1'b1;
    bus.wb_err_o = 1'b1;
    bus.wb_dat_o = 32'hCAFEF00D;
    tick();
    bus.wb_ack_o = 1'b0;
    bus.wb_err_o = 1'b0;
    bus.wb_dat_o = '0;
    check_rsp("ae_rsp", 32'd0, 1'b1, 1'b0);
    finish_rsp();
    check_idle("ae_done");
    // silent slave: abort after 8 bus cycles, late ack ignored
    do_req(1'b0, 10'h100, 32'd0, 4'hF);
    check_bus("to_c0", 1'b0, 10'h100, 32'd0, 4'hF);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("to_c%0d_cyc", i), 32'(bus.wb_cyc_i), 32'd1);
    end
    tick();
    check_rsp("to_rsp", 32'd0, 1'b0, 1'b1);
    bus.wb_ack_o = 1'b1;
    bus.wb_dat_o = 32'hFFFFFFFF;
    tick();
    bus.wb_ack_o = 1'b0;
    bus.wb_dat_o = '0;
    check_rsp("to_late", 32'd0, 1'b0, 1'b1);
    finish_rsp();
    check_idle("to_done");
    // ack on the last allowed cycle beats the timeout
    do_req(1'b0, 10'h101, 32'd0, 4'hF);
    for (int i = 1; i < 8; i++) tick();
    chk("edge_cyc", 32'(bus.wb_cyc_i), 32'd1);
    bus.wb_ack_o = 1'b1;
    bus.wb_dat_o = 32'hA5A5A5A5;
    tick();
    bus.wb_ack_o = 1'b0;
    bus.wb_dat_o = '0;
    check_rsp("edge_rsp", 32'hA5A5A5A5, 1'b0, 1'b0);
    finish_rsp();
    // reset two cycles into the bus cycle
    do_req(1'b1, 10'h020, 32'h55AA55AA, 4'hC);
    tick();
    tick();
    check_bus("rst_c3", 1'b1, 10'h020, 32'h55AA55AA, 4'hC);
    rst = 1'b1;
    tick();
    chk("rst_cyc", 32'(bus.wb_cyc_i), 32'd0);
    chk("rst_stb", 32'(bus.wb_stb_i), 32'd0);
    chk("rst_vld", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    tick();
    check_idle("rst_after");
    do_req(1'b1, 10'h021, 32'h11112222, 4'h1);
    check_bus("post_c1", 1'b1, 10'h021, 32'h11112222, 4'h1);
    bus.wb_ack_o = 1'b1;
    tick();
    bus.wb_ack_o = 1'b0;
    check_rsp("post_rsp", 32'd0, 1'b0, 1'b0);
    finish_rsp();
    // ten requests back to back, each response held 5 cycles before consumption
    for (int i = 0; i < 10; i++) begin
      do_req(1'b0, 10'(3 * i + 1), 32'd0, 4'(i + 1));
      check_bus($sformatf("b2b%0d", i), 1'b0, 10'(3 * i + 1), 32'd0, 4'(i + 1));
      bus.wb_ack_o = 1'b1;
      bus.wb_dat_o = 32'h1000_0000 + 32'(i);
      tick();
      bus.wb_ack_o = 1'b0;
      bus.wb_dat_o = '0;
      for (int k = 0; k < 5; k++) begin
        check_rsp($sformatf("b2b%0d_w%0d", i, k), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
        tick();
      end
      check_rsp($sformatf("b2b%0d_last", i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
      finish_rsp();
      check_idle($sformatf("b2b%0d_idle", i));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
